// File: rtl/idli_sqi_arb_m.sv
// idli_sqi_arb_m: arbiter/sequencer for the shared SQI memory pair.
// Two requesters (IF read-only, LS read/write) each get one 16-bit word
// transaction: grant -> start pulse -> wait for engine done -> ack.
// Optional fairness: define IDLI_SQI_ARB_FAIR_EN to bound the number of
// consecutive LS grants taken while IF is waiting (MAX_LS_RUN). Without it,
// LS has strict priority and IF can starve under continuous LS traffic.
module idli_sqi_arb_m #(
  parameter int MAX_LS_RUN = 4
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst_n,
  input  logic        i_if_req,
  input  logic [15:0] i_if_addr,
  output logic        o_if_ack,
  input  logic        i_ls_req,
  input  logic        i_ls_wr,
  input  logic [15:0] i_ls_addr,
  input  logic [15:0] i_ls_wdata,
  output logic        o_ls_ack,
  output logic [15:0] o_rdata,
  output logic        o_busy,
  output logic        o_sqi_start,
  output logic        o_sqi_wr,
  output logic [15:0] o_sqi_addr,
  output logic [15:0] o_sqi_wdata,
  input  logic        i_sqi_done,
  input  logic [15:0] i_sqi_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state;
  logic   owner_ls;   // 1: current transaction belongs to LS, 0: IF
  logic   grant_ls;   // arbitration result, only meaningful in IDLE with a request

`ifdef IDLI_SQI_ARB_FAIR_EN
  localparam int RUN_W = $clog2(MAX_LS_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_LS_RUN);

  logic [RUN_W-1:0] ls_run;
  logic             if_turn;

  // IF takes the grant once LS has won MAX_LS_RUN times in a row over it
  assign if_turn  = i_if_req && i_ls_req && (ls_run == RUN_MAX);
  assign grant_ls = i_ls_req && !if_turn;

  // Count consecutive LS grants that made a waiting IF lose; clear otherwise
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      ls_run <= '0;
    end else if ((state == IDLE) && (i_if_req || i_ls_req)) begin
      if (grant_ls && i_if_req) begin
        if (ls_run != RUN_MAX) begin
          ls_run <= ls_run + 1'b1;
        end
      end else begin
        ls_run <= '0;
      end
    end
  end
`else
  // Strict LS priority; MAX_LS_RUN has no effect in this build
  logic unused_max_ls_run;
  assign unused_max_ls_run = ^MAX_LS_RUN;
  assign grant_ls          = i_ls_req;
`endif

  // Transaction sequencer: all outputs are registered in this one block
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state       <= IDLE;
      owner_ls    <= 1'b0;
      o_if_ack    <= 1'b0;
      o_ls_ack    <= 1'b0;
      o_rdata     <= 16'h0000;
      o_busy      <= 1'b0;
      o_sqi_start <= 1'b0;
      o_sqi_wr    <= 1'b0;
      o_sqi_addr  <= 16'h0000;
      o_sqi_wdata <= 16'h0000;
    end else begin
      // Pulses default low; they are raised only on the entering transition
      o_sqi_start <= 1'b0;
      o_if_ack    <= 1'b0;
      o_ls_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_if_req || i_ls_req) begin
            state       <= ISSUE;
            o_busy      <= 1'b1;
            o_sqi_start <= 1'b1;
            owner_ls    <= grant_ls;
            if (grant_ls) begin
              o_sqi_wr    <= i_ls_wr;
              o_sqi_addr  <= i_ls_addr;
              o_sqi_wdata <= i_ls_wdata;
            end else begin
              o_sqi_wr    <= 1'b0;
              o_sqi_addr  <= i_if_addr;
              o_sqi_wdata <= 16'h0000;
            end
          end
        end
        ISSUE: begin
          // Engine completion cannot arrive before it has seen the start
          state <= WAIT;
        end
        WAIT: begin
          if (i_sqi_done) begin
            state   <= ACK;
            o_rdata <= o_sqi_wr ? 16'h0000 : i_sqi_rdata;
            if (owner_ls) begin
              o_ls_ack <= 1'b1;
            end else begin
              o_if_ack <= 1'b1;
            end
          end
        end
        ACK: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Testbench for idli_sqi_arb_m: directed steps, SQI engine model, and a
// scoreboard of expected starts/acks checked by a monitor.
module tb_idli_sqi_arb_m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic        ls_req;
  logic        ls_wr;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_ack;
  logic [15:0] rdata;
  logic        busy;
  logic        sqi_start;
  logic        sqi_wr;
  logic [15:0] sqi_addr;
  logic [15:0] sqi_wdata;
  logic        sqi_done;
  logic [15:0] sqi_rdata;

  logic        eng_done;
  logic [15:0] eng_rdata;
  logic        spur_done;
  logic [15:0] spur_rdata;

  assign sqi_done  = eng_done | spur_done;
  assign sqi_rdata = eng_done ? eng_rdata : spur_rdata;

  always #5 clk = ~clk;

  idli_sqi_arb_m #(.MAX_LS_RUN(4)) dut (
    .i_sqi_gck   (clk),
    .i_sqi_rst_n (rst_n),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_ack    (if_ack),
    .i_ls_req    (ls_req),
    .i_ls_wr     (ls_wr),
    .i_ls_addr   (ls_addr),
    .i_ls_wdata  (ls_wdata),
    .o_ls_ack    (ls_ack),
    .o_rdata     (rdata),
    .o_busy      (busy),
    .o_sqi_start (sqi_start),
    .o_sqi_wr    (sqi_wr),
    .o_sqi_addr  (sqi_addr),
    .o_sqi_wdata (sqi_wdata),
    .i_sqi_done  (sqi_done),
    .i_sqi_rdata (sqi_rdata)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } start_t;

  typedef struct {
    logic        is_ls;
    logic [15:0] rdata;
  } ack_t;

  start_t exp_start_q[$];
  ack_t   exp_ack_q[$];

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int eng_lat = 3;
  int last_done_cyc  = -100;
  int last_start_cyc = -100;

`ifdef IDLI_SQI_ARB_FAIR_EN
  localparam int         T4_N     = 6;
  localparam logic [6:0] T4_ORDER = 7'b0101111;  // LS,LS,LS,LS,IF,LS
`else
  localparam int         T4_N     = 7;
  localparam logic [6:0] T4_ORDER = 7'b0111111;  // LS x6, then IF
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Memory content returned by the engine model
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : ~a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_ls, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata);
    start_t s;
    ack_t   a;
    s.wr    = wr;
    s.addr  = addr;
    s.wdata = is_ls ? wdata : 16'h0000;
    a.is_ls = is_ls;
    a.rdata = wr ? 16'h0000 : mem_rd(addr);
    exp_start_q.push_back(s);
    exp_ack_q.push_back(a);
  endtask

  task automatic wait_ack(input string tag, output logic got_ls);
    got_ls = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_ack || ls_ack) begin
        got_ls = ls_ack;
        return;
      end
    end
    chk({tag, "_ack_timeout"}, 32'd1, 32'd0);
  endtask

  // SQI engine model: done eng_lat cycles after start, aborts on reset
  initial begin
    logic [15:0] a;
    bit          abort;
    eng_done  = 1'b0;
    eng_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && sqi_start) begin
        a     = sqi_addr;
        abort = 1'b0;
        for (int k = 0; k < eng_lat; k++) begin
          @(posedge clk);
          if (!rst_n) begin
            abort = 1'b1;
            break;
          end
        end
        if (!abort) begin
          #1;
          eng_done      = 1'b1;
          eng_rdata     = mem_rd(a);
          last_done_cyc = cyc;
          @(posedge clk);
          #1;
          eng_done  = 1'b0;
          eng_rdata = 16'h0000;
        end
      end
    end
  end

  // Monitor: compare every start and ack against the scoreboard
  initial begin
    start_t s;
    ack_t   a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sqi_start) begin
          if (exp_start_q.size() == 0) begin
            chk("start_unexpected", 32'd1, 32'd0);
          end else begin
            s = exp_start_q.pop_front();
            chk("start_wr", {31'd0, sqi_wr}, {31'd0, s.wr});
            chk("start_addr", {16'd0, sqi_addr}, {16'd0, s.addr});
            chk("start_wdata", {16'd0, sqi_wdata}, {16'd0, s.wdata});
          end
          if (last_start_cyc >= 0)
            chk("start_gap_ge4", {31'd0, (cyc - last_start_cyc) >= 4}, 32'd1);
          last_start_cyc = cyc;
        end
        if (if_ack || ls_ack) begin
          chk("ack_single", {31'd0, if_ack & ls_ack}, 32'd0);
          if (exp_ack_q.size() == 0) begin
            chk("ack_unexpected", 32'd1, 32'd0);
          end else begin
            a = exp_ack_q.pop_front();
            $display("ack: cyc=%0d owner=%s rdata=%h", cyc, ls_ack ? "LS" : "IF", rdata);
            chk("ack_owner_ls", {31'd0, ls_ack}, {31'd0, a.is_ls});
            chk("ack_rdata", {16'd0, rdata}, {16'd0, a.rdata});
            chk("ack_after_done", cyc, last_done_cyc + 1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    logic       g;
    int         ack_c;
    bit         seen;
    logic [6:0] t4_order;

    rst_n      = 1'b0;
    if_req     = 1'b0;
    if_addr    = 16'h0000;
    ls_req     = 1'b0;
    ls_wr      = 1'b0;
    ls_addr    = 16'h0000;
    ls_wdata   = 16'h0000;
    spur_done  = 1'b0;
    spur_rdata = 16'h0000;
    t4_order   = T4_ORDER;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, sqi_start}, 32'd0);
    chk("rst_acks", {31'd0, if_ack | ls_ack}, 32'd0);
    chk("rst_addr", {16'd0, sqi_addr}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // T1: single IF read, engine done 3 cycles after start
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h1234; eng_lat = 3;
    push_exp(1'b0, 1'b0, 16'h1234, 16'h0000);
    @(negedge clk); chk("t1_c0_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); chk("t1_c1_start", {31'd0, sqi_start}, 32'd1);
    repeat (4) @(negedge clk);
    chk("t1_c5_if_ack", {31'd0, if_ack}, 32'd1);
    chk("t1_c5_rdata", {16'd0, rdata}, 32'h0000BEEF);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk); chk("t1_c6_busy", {31'd0, busy}, 32'd0);

    // T2: LS write
    @(posedge clk); #1;
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 16'h0040; ls_wdata = 16'hA5A5; eng_lat = 2;
    push_exp(1'b1, 1'b1, 16'h0040, 16'hA5A5);
    wait_ack("t2", g);
    chk("t2_owner_ls", {31'd0, g}, 32'd1);
    chk("t2_rdata_zero", {16'd0, rdata}, 32'd0);
    @(posedge clk); #1 ls_req = 1'b0; ls_wr = 1'b0; ls_wdata = 16'h0000;

    // T3: IF and LS together, LS wins; IF start two cycles after LS ack
    @(posedge clk); #1;
    ls_req = 1'b1; ls_addr = 16'h0100; if_req = 1'b1; if_addr = 16'h0200; eng_lat = 3;
    push_exp(1'b1, 1'b0, 16'h0100, 16'h0000);
    push_exp(1'b0, 1'b0, 16'h0200, 16'h0000);
    wait_ack("t3a", g);
    chk("t3_first_is_ls", {31'd0, g}, 32'd1);
    ack_c = cyc;
    @(posedge clk); #1 ls_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sqi_start) seen = 1'b1;
    end
    chk("t3_if_start_seen", {31'd0, seen}, 32'd1);
    chk("t3_if_start_after_ack", cyc - ack_c, 32'd2);
    wait_ack("t3b", g);
    chk("t3_second_is_if", {31'd0, g}, 32'd0);
    @(posedge clk); #1 if_req = 1'b0;

    // T4: LS and IF held continuously; grant order depends on fairness
    @(posedge clk); #1;
    ls_req = 1'b1; ls_addr = 16'h0300; if_req = 1'b1; if_addr = 16'h0400; eng_lat = 2;
    for (int k = 0; k < T4_N; k++) begin
      if (t4_order[k]) push_exp(1'b1, 1'b0, 16'h0300, 16'h0000);
      else             push_exp(1'b0, 1'b0, 16'h0400, 16'h0000);
    end
    for (int k = 0; k < T4_N; k++) begin
      wait_ack("t4", g);
      chk("t4_grant_order", {31'd0, g}, {31'd0, t4_order[k]});
      @(posedge clk); #1;
      if (!g) if_req = 1'b0;
      if (k == 5) ls_req = 1'b0;
    end

    // T5: reset during WAIT, then a fresh IF transaction
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h2222; eng_lat = 6;
    push_exp(1'b0, 1'b0, 16'h2222, 16'h0000);
    @(negedge clk);
    @(negedge clk); chk("t5_c1_start", {31'd0, sqi_start}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_wr_start", {30'd0, sqi_wr, sqi_start}, 32'd0);
    chk("t5_rst_addr", {16'd0, sqi_addr}, 32'd0);
    chk("t5_rst_wdata", {16'd0, sqi_wdata}, 32'd0);
    chk("t5_rst_rdata", {16'd0, rdata}, 32'd0);
    chk("t5_rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
    exp_ack_q.delete();
    exp_start_q.delete();
    push_exp(1'b0, 1'b0, 16'h2222, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("t5_c0_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); chk("t5_c1_fresh_start", {31'd0, sqi_start}, 32'd1);
    wait_ack("t5", g);
    chk("t5_owner_if", {31'd0, g}, 32'd0);
    @(posedge clk); #1 if_req = 1'b0;

    // T6: spurious done in IDLE, then in ISSUE
    @(posedge clk); #1 spur_done = 1'b1; spur_rdata = 16'h1111;
    @(negedge clk); chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 spur_done = 1'b0;
    @(negedge clk);
    chk("t6_idle_busy2", {31'd0, busy}, 32'd0);
    chk("t6_idle_rdata", {16'd0, rdata}, 32'h0000DDDD);
    chk("t6_idle_noack", {30'd0, if_ack, ls_ack}, 32'd0);

    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h3000; eng_lat = 4;
    push_exp(1'b0, 1'b0, 16'h3000, 16'h0000);
    @(negedge clk);
    @(posedge clk); #1 spur_done = 1'b1; spur_rdata = 16'h1111;
    @(negedge clk); chk("t6_issue_start", {31'd0, sqi_start}, 32'd1);
    @(posedge clk); #1 spur_done = 1'b0;
    @(negedge clk);
    chk("t6_issue_busy", {31'd0, busy}, 32'd1);
    chk("t6_issue_rdata", {16'd0, rdata}, 32'h0000DDDD);
    chk("t6_issue_noack", {30'd0, if_ack, ls_ack}, 32'd0);
    wait_ack("t6", g);
    chk("t6_owner_if", {31'd0, g}, 32'd0);
    @(posedge clk); #1 if_req = 1'b0;

    repeat (4) @(negedge clk);
    chk("end_start_q_empty", exp_start_q.size(), 32'd0);
    chk("end_ack_q_empty", exp_ack_q.size(), 32'd0);
    chk("end_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
